// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arbiter_pkg;

  localparam int WORD_W = 32;

  // Which requester the read data returning next cycle belongs to
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/mem_arbiter_arb_prio2.sv
// rtl/mem_arbiter_arb_prio2.sv - two-way priority picker with starvation guard for the low-priority side
module arb_prio2 #(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_hi_i,
  input  logic req_lo_i,
  output logic gnt_hi_o,
  output logic gnt_lo_o
);

  logic [3:0] stall_q;
  logic [3:0] stall_d;
  logic       force_lo;

  // Low side has waited long enough: it takes the next cycle even against the high side
  assign force_lo = (stall_q == 4'(MAX_STALL));

  // Priority pick; nothing is granted while reset is held
  always_comb begin
    gnt_hi_o = 1'b0;
    gnt_lo_o = 1'b0;
    if (!rst) begin
      if (req_lo_i && (force_lo || !req_hi_i)) begin
        gnt_lo_o = 1'b1;
      end else if (req_hi_i) begin
        gnt_hi_o = 1'b1;
      end
    end
  end

  // Count consecutive denied low-side cycles, saturating at the force threshold
  always_comb begin
    stall_d = 4'd0;
    if (req_lo_i && !gnt_lo_o) begin
      stall_d = force_lo ? stall_q : stall_q + 4'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 4'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port RAM between instruction fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [WORD_W-1:0] mem_rdata
);

  resp_owner_e resp_q;
  resp_owner_e resp_d;

  // Byte-offset bits and address bits beyond the RAM depth are dropped on purpose
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Data side is the high-priority input; fetch is protected by the stall guard
  arb_prio2 #(
    .MAX_STALL (MAX_STALL)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_hi_i (d_req),
    .req_lo_i (if_req),
    .gnt_hi_o (d_gnt),
    .gnt_lo_o (if_gnt)
  );

  assign mem_en = if_gnt | d_gnt;
  assign mem_we = d_gnt & d_we;

  // Steer the granted requester onto the memory port; write fields only for data
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end
  end

  // Remember who issued this cycle's read; stores return nothing
  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt) begin
      resp_d = RESP_IF;
    end else if (d_gnt && !d_we) begin
      resp_d = RESP_D;
    end
  end

  // Response owner register; reset drops any in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign if_rvalid = (resp_q == RESP_IF);
  assign d_rvalid  = (resp_q == RESP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
